// File: rtl/cdm16_pic_if.sv
// CDM16 PIC bus: interrupt lines, core handshake and config register port.
// Channel count follows the N_CH parameter of the attached controller.
interface cdm16_pic_if #(
    parameter int N_CH = 8
);
    logic [N_CH-1:0] irq_src;
    logic            IAck;
    logic            eoi;
    logic            cfg_we;
    logic [1:0]      cfg_addr;
    logic [15:0]     cfg_wdata;
    logic [15:0]     cfg_rdata;
    logic            in_irq;
    logic [5:0]      int_vec;

    modport master (
        output irq_src, IAck, eoi,
        output cfg_we, cfg_addr, cfg_wdata,
        input  cfg_rdata, in_irq, int_vec
    );

    modport slave (
        input  irq_src, IAck, eoi,
        input  cfg_we, cfg_addr, cfg_wdata,
        output cfg_rdata, in_irq, int_vec
    );
endinterface

// File: rtl/cdm16_pic.sv
// CDM16 fixed-priority interrupt controller, state clocked on negedge.
// Define PIC_NESTING_EN to let higher-priority channels preempt service.
module cdm16_pic #(
    parameter int N_CH     = 8,
    parameter int VEC_BASE = 16
) (
    input  logic        input_clock,
    input  logic        rst,
    cdm16_pic_if.slave  bus
);
    typedef logic [N_CH-1:0] vec_t;
    localparam logic [5:0] VB = 6'(VEC_BASE);

    vec_t mask_q, mask_d;
    vec_t mode_q, mode_d;
    vec_t pend_q, pend_d;
    vec_t insv_q, insv_d;
    vec_t prev_q;
    logic       in_irq_q, in_irq_d;
    logic [5:0] int_vec_q, int_vec_d;

    vec_t edge_ev, ack_oh, eoi_oh, w1c;
    vec_t cand, elig, win;
    logic ack;
`ifdef PIC_NESTING_EN
    vec_t lowest;
`endif

    always_comb begin
        edge_ev = bus.irq_src & ~prev_q;
        ack     = bus.IAck & in_irq_q;
        ack_oh  = '0;
        for (int i = 0; i < N_CH; i++) begin
            if (ack && int_vec_q == VB + 6'(i))
                ack_oh[i] = 1'b1;
        end
        eoi_oh = bus.eoi ? (insv_q & (~insv_q + vec_t'(1))) : '0;
        w1c    = '0;
        mask_d = mask_q;
        mode_d = mode_q;
        if (bus.cfg_we) begin
            unique case (bus.cfg_addr)
                2'd0: mask_d = bus.cfg_wdata[N_CH-1:0];
                2'd1: mode_d = bus.cfg_wdata[N_CH-1:0];
                2'd2: w1c    = bus.cfg_wdata[N_CH-1:0];
                2'd3: ;
            endcase
        end
        insv_d = (insv_q & ~eoi_oh) | ack_oh;
        // Edge-mode set beats any clear; level mode just mirrors the line.
        pend_d = (mode_q & (edge_ev | (pend_q & ~w1c & ~ack_oh)))
               | (~mode_q & bus.irq_src);
        cand = pend_q & ~mask_q;
`ifdef PIC_NESTING_EN
        lowest = insv_d & (~insv_d + vec_t'(1));
        elig   = (lowest == '0) ? '1 : lowest - vec_t'(1);
`else
        elig   = (insv_d == '0) ? '1 : '0;
`endif
        win       = cand & elig;
        in_irq_d  = 1'b0;
        int_vec_d = int_vec_q;
        for (int i = N_CH - 1; i >= 0; i--) begin
            if (win[i]) begin
                in_irq_d  = 1'b1;
                int_vec_d = VB + 6'(i);
            end
        end
    end

    always_comb begin
        bus.cfg_rdata = '0;
        unique case (bus.cfg_addr)
            2'd0: bus.cfg_rdata[N_CH-1:0] = mask_q;
            2'd1: bus.cfg_rdata[N_CH-1:0] = mode_q;
            2'd2: bus.cfg_rdata[N_CH-1:0] = pend_q;
            2'd3: bus.cfg_rdata[N_CH-1:0] = insv_q;
        endcase
    end

    assign bus.in_irq  = in_irq_q;
    assign bus.int_vec = int_vec_q;

    always_ff @(negedge input_clock or posedge rst) begin
        if (rst) begin
            mask_q    <= '1;
            mode_q    <= '1;
            pend_q    <= '0;
            insv_q    <= '0;
            prev_q    <= '0;
            in_irq_q  <= 1'b0;
            int_vec_q <= '0;
        end else begin
            mask_q    <= mask_d;
            mode_q    <= mode_d;
            pend_q    <= pend_d;
            insv_q    <= insv_d;
            prev_q    <= bus.irq_src;
            in_irq_q  <= in_irq_d;
            int_vec_q <= int_vec_d;
        end
    end
endmodule

// File: doc/cdm16_pic.md
CDM16_PIC -- requirements
Module: cdm16_pic

Interface
REQ-001 SHALL have parameter N_CH, default 8, meaning number of interrupt channels (legal range 1..16).
REQ-002 SHALL have parameter VEC_BASE, default 16, meaning 6-bit vector of channel 0 (VEC_BASE+N_CH-1 <= 63).
REQ-003 SHALL have port input_clock  in  1  sole clock; all state updates on negedge input_clock, matching the core.
REQ-004 SHALL have port rst  in  1  reset, asynchronous, active-high.
REQ-005 SHALL have port irq_src  in  N_CH  raw interrupt request lines, asynchronous to nothing (already in clock domain).
REQ-006 SHALL have port IAck  in  1  core acknowledge pulse, one clock, taken while in_irq high.
REQ-007 SHALL have port eoi  in  1  end-of-interrupt pulse from the ISR.
REQ-008 SHALL have ports cfg_we  in  1 / cfg_addr  in  2 / cfg_wdata  in  16  register write port.
REQ-009 SHALL have port cfg_rdata  out  16  combinational read data for cfg_addr.
REQ-010 SHALL have port in_irq  out  1  interrupt request to core (registered).
REQ-011 SHALL have port int_vec  out  6  vector of presented channel (registered).

Function
REQ-012 SHALL keep registers MASK (addr 0, 1 = masked), MODE (addr 1, 1 = edge, 0 = level), PEND (addr 2, read; write-1-to-clear), INSV (addr 3, read-only); bits >= N_CH read 0, writes ignored.
REQ-013 SHALL register irq_src once per clock into prev; edge event for channel i = irq_src[i] & !prev[i].
REQ-014 SHALL set PEND[i] on edge event when MODE[i]=1; SHALL set PEND[i] = irq_src[i] each clock when MODE[i]=0 (level follows line, W1C has no lasting effect).
REQ-015 SHALL compute candidates = PEND & ~MASK; priority fixed, lowest index highest.
REQ-016 SHALL define winner = lowest-index candidate eligible under REQ-027/REQ-028; SHALL load in_irq <= (winner exists), int_vec <= VEC_BASE + winner index (unchanged when none) each clock: latency 1 clock from PEND set to in_irq.
REQ-017 On IAck, SHALL move the channel currently encoded by int_vec: INSV[ch] <= 1, and in edge mode PEND[ch] <= 0.
REQ-018 SHALL drop in_irq the clock after IAck unless another eligible candidate exists.
REQ-019 IAck while in_irq=0 SHALL be ignored.
REQ-020 On eoi, SHALL clear the lowest-index set INSV bit; eoi with INSV=0 ignored.
REQ-021 Simultaneous edge event and IAck clear on same channel: set wins, PEND stays 1.
REQ-022 Simultaneous edge event and PEND W1C on same channel: set wins.
REQ-023 Simultaneous eoi and IAck: eoi applied to pre-IAck INSV, then IAck bit set.
REQ-024 MASK write SHALL not alter PEND; masked pending channels are presented once unmasked (1 clock later).
REQ-025 MODE change SHALL take effect the next clock; PEND bits are not cleared by it.

Reset
REQ-026 While rst high: PEND=0, INSV=0, prev=0, MASK=all ones, MODE=all ones, in_irq=0, int_vec=0; release takes effect on first clock edge after deassertion; rst mid-service discards INSV and PEND.

Configuration
REQ-027 With PIC_NESTING_EN defined, a candidate SHALL be eligible only if its index is lower than the lowest set INSV bit (higher priority preempts; equal/lower wait).
REQ-028 Without PIC_NESTING_EN, no candidate SHALL be eligible while any INSV bit is set (single-level; INSV holds at most one bit).

Verification
REQ-029 Reset, unmask ch3 (MASK=0xFFF7), edge on irq_src[3] -> in_irq=1, int_vec=19 one clock after PEND[3]; IAck -> INSV=0x0008, PEND=0, in_irq=0 next clock.
REQ-030 Edges on ch5 and ch2 same clock, all unmasked -> int_vec=18 first; after IAck+eoi -> int_vec=21.
REQ-031 PIC_NESTING_EN: ch4 in service, edge on ch1 -> in_irq=1, int_vec=17; edge on ch6 -> in_irq stays 0 until both eoi; without macro, ch1 also held off until eoi.
REQ-032 Level mode ch0 (MODE=0xFFFE), line held high through IAck and eoi -> in_irq reasserts after eoi; line low -> PEND[0]=0 next clock.
REQ-033 Edge on ch7 in same clock as W1C of PEND bit 7 -> PEND[7]=1; rst asserted with INSV=0x0080 -> all registers at reset values immediately, in_irq=0.
